shift_add_mult4: RTL and testbench



---
 rtl/shift_add_mult4_pkg.sv | 18 +
 rtl/shift_add_mult4_if.sv | 27 ++
 rtl/shift_add_mult4_adder4bit.sv | 27 ++
 rtl/shift_add_mult4.sv | 96 +++++++++
 tb/tb_shift_add_mult4.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/shift_add_mult4_pkg.sv
// Shared constants and types for the shift-and-add 4x4 multiplier.
//   state_e    : FSM state encoding (IDLE/CALC/DONE; 2'd3 unused)
//   OP_W       : operand width (matches adder4bit)
//   ITERATIONS : one multiplier bit consumed per CALC cycle
//   PROD_W     : product width
package shift_add_mult4_pkg;

  localparam int OP_W       = 4;
  localparam int ITERATIONS = 4;
  localparam int PROD_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mult4_if.sv
// Start/done handshake bundle between the lab top level and the multiplier.
//   start        : request a multiply (master -> slave)
//   multiplicand : operand A, unsigned (master -> slave)
//   multiplier   : operand B, unsigned (master -> slave)
//   busy         : iterating (slave -> master)
//   done         : one-cycle completion pulse (slave -> master)
//   product      : registered 8-bit result (slave -> master)
interface shift_add_mult4_if;
  import shift_add_mult4_pkg::*;

  logic              start;
  logic [OP_W-1:0]   multiplicand;
  logic [OP_W-1:0]   multiplier;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mult4_adder4bit.sv
// adder4bit: 4-bit ripple-carry adder built from a chain of full adders.
//   a_i, b_i : addends
//   cin_i    : carry in
//   s_o      : 4-bit sum
//   cout_o   : carry out of the MSB
module adder4bit
  import shift_add_mult4_pkg::*;
(
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  input  logic            cin_i,
  output logic [OP_W-1:0] s_o,
  output logic            cout_o
);

  logic [OP_W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < OP_W; i++) begin : g_fa
    assign s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[OP_W];

endmodule

// File: rtl/shift_add_mult4.sv
// shift_add_mult4: sequential 4x4 unsigned multiplier, one multiplier bit
// per cycle through a single adder4bit; 8-bit product after 4 iterations.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; abandons any operation in flight
//   bus   : slave side of the start/busy/done/product handshake
module shift_add_mult4
  import shift_add_mult4_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  shift_add_mult4_if.slave bus
);

  state_e            state_q;
  logic [OP_W-1:0]   mcand_q;
  logic [OP_W-1:0]   acc_q;
  logic [OP_W-1:0]   mq_q;
  logic [2:0]        cnt_q;
  logic [PROD_W-1:0] product_q;
  logic              busy_q;
  logic              done_q;

  logic [OP_W-1:0]   sum;
  logic              cout;
  logic [PROD_W-1:0] shifted_d;
  logic              last_iter;

  adder4bit u_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .cin_i (1'b0),
    .s_o   (sum),
    .cout_o(cout)
  );

  // Add-then-shift of {acc,mq}: the adder carry becomes the new MSB, so the
  // 9th bit of the partial sum is never dropped.
  always_comb begin
    shifted_d = {1'b0, acc_q, mq_q[OP_W-1:1]};
    if (mq_q[0]) shifted_d = {cout, sum, mq_q[OP_W-1:1]};
  end

  assign last_iter = (cnt_q == 3'(ITERATIONS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new start just like IDLE, giving back-to-back
        // operation every 5 cycles.
        ST_IDLE, ST_DONE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            mcand_q <= bus.multiplicand;
            mq_q    <= bus.multiplier;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          {acc_q, mq_q} <= shifted_d;
          cnt_q         <= cnt_q + 3'd1;
          if (last_iter) begin
            // Product captured from the final shifted value on DONE entry.
            product_q <= shifted_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult4.sv
module tb_shift_add_mult4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  shift_add_mult4_if bus ();

  shift_add_mult4 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: product 0x%0h with no pending operation", bus.product);
      end else begin
        chk("product", int'(bus.product), int'(exp_q.pop_front()));
      end
    end
  end

  // Issue one multiply; measure latency to done and busy width.
  // poke=1 pulses start with 2x2 during CALC (must be ignored).
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input bit poke);
    int busy_cnt;
    int lat;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.multiplicand = 4'hx;
    bus.multiplier = 4'hx;
    busy_cnt = int'(bus.busy);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (poke && k == 1) begin
        bus.start = 1'b1;
        bus.multiplicand = 4'd2;
        bus.multiplier = 4'd2;
      end
      @(posedge clk); #1;
      if (poke && k == 1) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
      busy_cnt += int'(bus.busy);
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within 8 cycles for %0d x %0d", a, b);
    end else begin
      chk("latency", lat, 4);
      chk("busy_cycles", busy_cnt, 4);
      chk("busy_in_done", int'(bus.busy), 0);
    end
    @(posedge clk); #1;
    chk("done_width", int'(bus.done), 0);
    chk("product_hold", int'(bus.product), int'(exp));
  endtask

  initial begin
    int d1;
    int d2;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = 4'd0;
    bus.multiplier = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_product", int'(bus.product), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'd0,  4'd0,  8'h00, 1'b0);
    run_op(4'd15, 4'd1,  8'h0F, 1'b0);
    run_op(4'd15, 4'd15, 8'hE1, 1'b0);
    run_op(4'd13, 4'd11, 8'h8F, 1'b0);
    run_op(4'd1,  4'd15, 8'h0F, 1'b0);
    run_op(4'd6,  4'd7,  8'h2A, 1'b1);

    // Reset during the 3rd CALC cycle of 9x9: abandoned, no done.
    bus.start = 1'b1;
    bus.multiplicand = 4'd9;
    bus.multiplier = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_product", int'(bus.product), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_product_idle", int'(bus.product), 0);
    run_op(4'd9, 4'd9, 8'h51, 1'b0);

    // Back-to-back: start held with 3x5, then 4x4 presented before DONE.
    d1 = 0;
    d2 = 0;
    bus.start = 1'b1;
    bus.multiplicand = 4'd3;
    bus.multiplier = 4'd5;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h10);
    @(posedge clk); #1;
    bus.multiplicand = 4'd4;
    bus.multiplier = 4'd4;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 5) bus.start = 1'b0;
      if (bus.done) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
    end
    chk("b2b_first_done", d1, 4);
    chk("b2b_second_done", d2, 9);
    chk("b2b_final_product", int'(bus.product), 8'h10);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
